la_rle_decoder: RTL and testbench

LA_RLE_DECODER -- requirements
Module: la_rle_decoder

---
 rtl/la_rle_decoder.sv | 127 ++++++++++++
 tb/tb_la_rle_decoder.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/la_rle_decoder.sv
// Run-length decoder: expands {count, sample} words into count repeated samples
// on an AXI-Stream output, with statistics counters and a sticky zero-count flag.
module la_rle_decoder #(
  parameter int pDATA_WIDTH   = 32,
  parameter int pSAMPLE_WIDTH = 24,
  parameter int pCNT_WIDTH    = 8
) (
  input  logic                     axis_clk,
  input  logic                     axis_rst_n,
  input  logic                     enable,
  input  logic                     cnt_clr,
  input  logic [pDATA_WIDTH-1:0]   s_tdata,
  input  logic                     s_tvalid,
  output logic                     s_tready,
  input  logic                     s_tlast,
  output logic [pSAMPLE_WIDTH-1:0] m_tdata,
  output logic                     m_tvalid,
  input  logic                     m_tready,
  output logic                     m_tlast,
  output logic [31:0]              sample_count,
  output logic [15:0]              word_count,
  output logic                     zero_cnt_err
);

  typedef enum logic {IDLE, EXPAND} state_t;

  state_t                   state_q, state_d;
  logic [pCNT_WIDTH-1:0]    rem_q, rem_d;
  logic [pSAMPLE_WIDTH-1:0] data_q, data_d;
  logic                     last_flag_q, last_flag_d;
  logic                     tvalid_q, tvalid_d;
  logic                     tlast_q, tlast_d;
  logic [31:0]              sample_count_q, sample_count_d;
  logic [15:0]              word_count_q, word_count_d;
  logic                     zero_err_q, zero_err_d;

  logic [pCNT_WIDTH-1:0]    in_cnt;
  logic [pSAMPLE_WIDTH-1:0] in_sample;
  logic                     final_beat;
  logic                     accept;

  assign in_cnt    = s_tdata[pDATA_WIDTH-1 -: pCNT_WIDTH];
  assign in_sample = s_tdata[pSAMPLE_WIDTH-1:0];

  // A new word may only enter when nothing is owed or the last owed beat leaves now.
  assign final_beat = (state_q == EXPAND) && (rem_q == pCNT_WIDTH'(1)) && m_tready;
  assign s_tready   = axis_rst_n && enable && ((state_q == IDLE) || final_beat);
  assign accept     = s_tvalid && s_tready;

  always_comb begin
    state_d        = state_q;
    rem_d          = rem_q;
    data_d         = data_q;
    last_flag_d    = last_flag_q;
    tvalid_d       = tvalid_q;
    tlast_d        = tlast_q;
    sample_count_d = sample_count_q;
    word_count_d   = word_count_q;
    zero_err_d     = zero_err_q;

    if ((state_q == EXPAND) && m_tready) begin
      sample_count_d = sample_count_q + 32'd1;
      if (rem_q != pCNT_WIDTH'(1)) begin
        rem_d   = rem_q - pCNT_WIDTH'(1);
        tlast_d = last_flag_q && (rem_q == pCNT_WIDTH'(2));
      end else begin
        state_d  = IDLE;
        rem_d    = '0;
        tvalid_d = 1'b0;
        tlast_d  = 1'b0;
      end
    end

    // An accepted word overrides the IDLE transition taken on a final beat.
    if (accept) begin
      word_count_d = word_count_q + 16'd1;
      if (in_cnt == '0) begin
        zero_err_d = 1'b1;
      end else begin
        state_d     = EXPAND;
        rem_d       = in_cnt;
        data_d      = in_sample;
        last_flag_d = s_tlast;
        tvalid_d    = 1'b1;
        tlast_d     = s_tlast && (in_cnt == pCNT_WIDTH'(1));
      end
    end

    if (cnt_clr) begin
      sample_count_d = '0;
      word_count_d   = '0;
      zero_err_d     = 1'b0;
    end
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      state_q        <= IDLE;
      rem_q          <= '0;
      data_q         <= '0;
      last_flag_q    <= 1'b0;
      tvalid_q       <= 1'b0;
      tlast_q        <= 1'b0;
      sample_count_q <= '0;
      word_count_q   <= '0;
      zero_err_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      rem_q          <= rem_d;
      data_q         <= data_d;
      last_flag_q    <= last_flag_d;
      tvalid_q       <= tvalid_d;
      tlast_q        <= tlast_d;
      sample_count_q <= sample_count_d;
      word_count_q   <= word_count_d;
      zero_err_q     <= zero_err_d;
    end
  end

  assign m_tdata      = data_q;
  assign m_tvalid     = tvalid_q;
  assign m_tlast      = tlast_q;
  assign sample_count = sample_count_q;
  assign word_count   = word_count_q;
  assign zero_cnt_err = zero_err_q;

endmodule

// File: tb/tb_la_rle_decoder.sv
// Directed bench for la_rle_decoder: a queue model of owed beats checked every
// cycle, plus literal expectations for the documented scenarios.
module tb_la_rle_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        cnt_clr;
  logic [31:0] s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic        s_tlast;
  logic [23:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;
  logic [31:0] sample_count;
  logic [15:0] word_count;
  logic        zero_cnt_err;

  la_rle_decoder dut (
    .axis_clk     (clk),
    .axis_rst_n   (rst_n),
    .enable       (enable),
    .cnt_clr      (cnt_clr),
    .s_tdata      (s_tdata),
    .s_tvalid     (s_tvalid),
    .s_tready     (s_tready),
    .s_tlast      (s_tlast),
    .m_tdata      (m_tdata),
    .m_tvalid     (m_tvalid),
    .m_tready     (m_tready),
    .m_tlast      (m_tlast),
    .sample_count (sample_count),
    .word_count   (word_count),
    .zero_cnt_err (zero_cnt_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Model: every beat still owed, in order; bit 24 marks the capture-final beat.
  logic [24:0] q[$];
  logic [31:0] sc_m = 0;
  logic [15:0] wc_m = 0;
  logic        err_m = 1'b0;

  logic [23:0] log_data[$];
  int          log_cyc[$];
  bit          log_last[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic exp_ready;
    int   n;
    if (!rst_n) begin
      chk("rst_s_tready", {31'd0, s_tready}, 0);
      chk("rst_m_tvalid", {31'd0, m_tvalid}, 0);
      chk("rst_m_tdata", {8'd0, m_tdata}, 0);
      chk("rst_sample_count", sample_count, 0);
      q.delete();
      sc_m  = 0;
      wc_m  = 0;
      err_m = 1'b0;
    end else begin
      exp_ready = enable && (q.size() == 0 || (q.size() == 1 && m_tready));
      chk("s_tready", {31'd0, s_tready}, {31'd0, exp_ready});
      chk("m_tvalid", {31'd0, m_tvalid}, {31'd0, q.size() != 0});
      if (q.size() != 0) begin
        chk("m_tdata", {8'd0, m_tdata}, {8'd0, q[0][23:0]});
        chk("m_tlast", {31'd0, m_tlast}, {31'd0, q[0][24]});
      end
      chk("sample_count", sample_count, sc_m);
      chk("word_count", {16'd0, word_count}, {16'd0, wc_m});
      chk("zero_cnt_err", {31'd0, zero_cnt_err}, {31'd0, err_m});
      if (q.size() != 0 && m_tready) begin
        log_data.push_back(m_tdata);
        log_cyc.push_back(cyc);
        log_last.push_back(m_tlast);
        void'(q.pop_front());
        sc_m = sc_m + 1;
      end
      if (s_tvalid && exp_ready) begin
        wc_m = wc_m + 1;
        n = int'(s_tdata[31:24]);
        if (n == 0) err_m = 1'b1;
        for (int i = 0; i < n; i++)
          q.push_back({s_tlast && (i == n - 1), s_tdata[23:0]});
      end
      if (cnt_clr) begin
        sc_m  = 0;
        wc_m  = 0;
        err_m = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] w, input logic last);
    bit acc = 1'b0;
    s_tdata  = w;
    s_tlast  = last;
    s_tvalid = 1'b1;
    for (int i = 0; i < 600 && !acc; i++) begin
      @(negedge clk);
      acc = s_tready;
      tick();
    end
    acc_cyc  = cyc;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    if (!acc) begin
      errors++;
      $display("FAIL send_timeout: word %0h never accepted", w);
    end
  endtask

  task automatic wait_idle();
    bit idle = 1'b0;
    for (int i = 0; i < 1000 && !idle; i++) begin
      @(negedge clk);
      idle = !m_tvalid;
    end
    tick();
    if (!idle) begin
      errors++;
      $display("FAIL idle_timeout: m_tvalid stuck high");
    end
  endtask

  task automatic clr();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    log_data.delete();
    log_cyc.delete();
    log_last.delete();
  endtask

  initial begin
    logic [23:0] exp22[7];
    bit          pat[7];
    int          nlast;
    exp22 = '{24'h5, 24'h5, 24'h6, 24'h7, 24'h7, 24'h7, 24'h7};
    pat   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    rst_n = 1'b0; enable = 1'b1; cnt_clr = 1'b0;
    s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b1;
    repeat (3) tick();
    chk("reset_s_tready", {31'd0, s_tready}, 0);
    chk("reset_word_count", {16'd0, word_count}, 0);
    rst_n = 1'b1;
    tick();

    // Single word, latency 1, three consecutive beats
    clr();
    send(32'h03_000001, 1'b0);
    wait_idle();
    chk("single_beats", log_data.size(), 3);
    if (log_data.size() == 3) begin
      chk("single_latency", log_cyc[0], acc_cyc);
      for (int i = 0; i < 3; i++) begin
        chk("single_data", {8'd0, log_data[i]}, 32'h1);
        chk("single_cycle", log_cyc[i], log_cyc[0] + i);
      end
    end
    chk("single_sample_count", sample_count, 3);
    chk("single_word_count", {16'd0, word_count}, 1);

    // Back-to-back words, no bubble
    clr();
    send(32'h02_000005, 1'b0);
    send(32'h01_000006, 1'b0);
    send(32'h04_000007, 1'b0);
    wait_idle();
    chk("b2b_beats", log_data.size(), 7);
    if (log_data.size() == 7)
      for (int i = 0; i < 7; i++) begin
        chk("b2b_data", {8'd0, log_data[i]}, {8'd0, exp22[i]});
        chk("b2b_cycle", log_cyc[i], log_cyc[0] + i);
      end

    // Backpressure pattern
    clr();
    send(32'h04_123456, 1'b0);
    for (int i = 0; i < 7; i++) begin
      m_tready = pat[i];
      tick();
    end
    m_tready = 1'b1;
    wait_idle();
    chk("stall_beats", log_data.size(), 4);
    foreach (log_data[i]) chk("stall_data", {8'd0, log_data[i]}, 32'h123456);

    // Zero-count word
    clr();
    send(32'h00_ABCDEF, 1'b0);
    send(32'h01_000002, 1'b0);
    wait_idle();
    chk("zero_err", {31'd0, zero_cnt_err}, 1);
    chk("zero_word_count", {16'd0, word_count}, 2);
    chk("zero_beats", log_data.size(), 1);
    if (log_data.size() == 1) chk("zero_data", {8'd0, log_data[0]}, 32'h2);

    // enable dropped mid-expansion
    clr();
    send(32'h03_000011, 1'b0);
    enable   = 1'b0;
    s_tdata  = 32'h02_000022;
    s_tvalid = 1'b1;
    repeat (6) tick();
    chk("dis_word_count", {16'd0, word_count}, 1);
    chk("dis_beats", log_data.size(), 3);
    enable = 1'b1;
    send(32'h02_000022, 1'b0);
    wait_idle();
    chk("dis_resume_beats", log_data.size(), 5);

    // cnt_clr coinciding with a beat
    clr();
    send(32'h04_000033, 1'b0);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("clr_collide", sample_count, 0);
    wait_idle();
    chk("clr_after", sample_count, 3);

    // Count 255 with s_tlast
    clr();
    send(32'hFF_000009, 1'b1);
    wait_idle();
    chk("max_beats", log_data.size(), 255);
    chk("max_sample_count", sample_count, 255);
    nlast = 0;
    foreach (log_last[i]) nlast += int'(log_last[i]);
    chk("max_nlast", nlast, 1);
    if (log_last.size() == 255) chk("max_last_pos", {31'd0, log_last[254]}, 1);

    // Asynchronous reset mid-expansion
    clr();
    send(32'h05_00000A, 1'b0);
    repeat (2) tick();
    chk("mid_beats", log_data.size(), 2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_m_tvalid", {31'd0, m_tvalid}, 0);
    chk("arst_m_tdata", {8'd0, m_tdata}, 0);
    chk("arst_m_tlast", {31'd0, m_tlast}, 0);
    chk("arst_sample_count", sample_count, 0);
    chk("arst_word_count", {16'd0, word_count}, 0);
    chk("arst_s_tready", {31'd0, s_tready}, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_sample_count", sample_count, 0);
    chk("post_rst_m_tvalid", {31'd0, m_tvalid}, 0);
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
